// File: rtl/inv_mixcol_seq.sv
// inv_mixcol_seq: iterative AES InvMixColumns, one column per clock through a shared GF(2^8) multiplier bank,
// with an optional pass-through for the final decryption round.
module inv_mixcol_seq #(
    parameter logic BYPASS_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_bypass,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e         state_q, state_d;
    logic [1:0]     col_q, col_d;
    logic [127:0]   src_q, src_d, res_q, res_d;
    logic [31:0]    a, b;
    logic [6:0]     sh;

    function automatic logic [7:0] xt(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    // constant multiply: k is one of 9/b/d/e, composed from the doubling chain
    function automatic logic [7:0] gm(input logic [7:0] v, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xt(v);
        x4 = xt(x2);
        x8 = xt(x4);
        return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[0] ? v : 8'h00);
    endfunction

    always_comb begin
        sh = 7'd96 - {col_q, 5'd0};
        a  = 32'(src_q >> sh);
        b  = {gm(a[31:24], 4'he) ^ gm(a[23:16], 4'hb) ^ gm(a[15:8], 4'hd) ^ gm(a[7:0], 4'h9),
              gm(a[31:24], 4'h9) ^ gm(a[23:16], 4'he) ^ gm(a[15:8], 4'hb) ^ gm(a[7:0], 4'hd),
              gm(a[31:24], 4'hd) ^ gm(a[23:16], 4'h9) ^ gm(a[15:8], 4'he) ^ gm(a[7:0], 4'hb),
              gm(a[31:24], 4'hb) ^ gm(a[23:16], 4'hd) ^ gm(a[15:8], 4'h9) ^ gm(a[7:0], 4'he)};
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        src_d   = src_q;
        res_d   = res_q;
        if (flush) begin
            state_d = IDLE;
            col_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    src_d = in_state;
                    if (BYPASS_EN && in_bypass) begin
                        res_d   = in_state;
                        state_d = DONE;
                    end else begin
                        col_d   = '0;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    res_d   = (res_q & ~(128'hffffffff << sh)) | (128'(b) << sh);
                    col_d   = col_q + 2'd1;
                    state_d = (col_q == 2'd3) ? DONE : BUSY;
                end
                DONE: state_d = out_ready ? IDLE : DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            src_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            src_q   <= src_d;
            res_q   <= res_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == BUSY);
    assign out_state = res_q;
endmodule

// File: tb/tb_inv_mixcol_seq.sv
// tb_inv_mixcol_seq: directed and random checks of inv_mixcol_seq against a matrix-level GF(2^8) model.
module tb_inv_mixcol_seq;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         iv = 1'b0, ib = 1'b0, fl = 1'b0, ordy = 1'b0;
    logic [127:0] ist = '0;
    logic         ir, ov, bz;
    logic [127:0] ost;
    logic         iv1 = 1'b0, ib1 = 1'b0, ordy1 = 1'b1;
    logic [127:0] ist1 = '0;
    logic         ir1, ov1, bz1;
    logic [127:0] ost1;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inv_mixcol_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .in_state(ist), .in_bypass(ib),
        .flush(fl), .out_valid(ov), .out_ready(ordy), .out_state(ost), .busy(bz)
    );

    inv_mixcol_seq #(.BYPASS_EN(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_state(ist1), .in_bypass(ib1),
        .flush(1'b0), .out_valid(ov1), .out_ready(ordy1), .out_state(ost1), .busy(bz1)
    );

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    // row r of the inverse matrix is {0e,0b,0d,09} rotated right by r
    function automatic logic [127:0] ref_imc(input logic [127:0] s);
        logic [7:0] coef [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        logic [7:0] bytes [16];
        logic [127:0] r = '0;
        for (int k = 0; k < 16; k++) bytes[k] = s[127-8*k -: 8];
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) begin
                logic [7:0] acc = 8'h00;
                for (int k = 0; k < 4; k++) acc ^= gmul(coef[(k - row + 4) % 4], bytes[4*c+k]);
                r[127-8*(4*c+row) -: 8] = acc;
            end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_block(input logic [127:0] s, input logic byp, input string tag);
        int cyc;
        chk({tag, " idle"}, ir, 1'b1);
        ist = s; ib = byp; iv = 1'b1; ordy = 1'b1;
        step();
        iv = 1'b0; ib = 1'b0; ist = ~s;
        cyc = 1;
        while (!ov && cyc < 20) begin step(); cyc++; end
        chk({tag, " latency"}, cyc, byp ? 1 : 5);
        chk({tag, " data"}, ost, byp ? s : ref_imc(s));
        step();
        chk({tag, " pulse"}, {ov, ir}, 2'b01);
    endtask

    initial begin
        int cyc, n;
        logic [127:0] s, e, ra;
        logic seen;
        #3;
        chk("reset", {ir, ov, bz}, 3'b100);
        chk("reset_state", ost, '0);
        step();
        rst_n = 1'b1;
        step();

        chk("model_vec", ref_imc(128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6), 128'hdb135345_f20a225c_01010101_d4d4d4d5);
        run_block(128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6, 1'b0, "vec");
        chk("vec_const", ost, 128'hdb135345_f20a225c_01010101_d4d4d4d5);
        run_block(128'h00112233_44556677_8899aabb_ccddeeff, 1'b1, "bypass");

        s = 128'h00112233_44556677_8899aabb_ccddeeff;
        ist1 = s; ib1 = 1'b1; iv1 = 1'b1;
        step();
        iv1 = 1'b0;
        cyc = 1;
        while (!ov1 && cyc < 20) begin step(); cyc++; end
        chk("nobypass latency", cyc, 5);
        chk("nobypass data", ost1, ref_imc(s));

        for (int t = 0; t < 8; t++)
            run_block({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)), "rand");

        s = {$urandom, $urandom, $urandom, $urandom};
        e = ref_imc(s);
        ordy = 1'b0; ist = s; ib = 1'b0; iv = 1'b1;
        step();
        ist = ~s; ib = 1'b1;
        cyc = 1;
        while (!ov && cyc < 20) begin step(); cyc++; end
        chk("bp latency", cyc, 5);
        for (int t = 0; t < 10; t++) begin
            step();
            chk("bp hold", ost, e);
            chk("bp flags", {ov, ir}, 2'b10);
        end
        ordy = 1'b1; iv = 1'b0; ib = 1'b0;
        step();
        chk("bp release", {ov, ir}, 2'b01);
        chk("bp no_accept", ost, e);

        s  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
        ra = {4{32'h4d7ebdf8}};
        ist = s; iv = 1'b1; ordy = 1'b1;
        step();
        ist = ra;
        n = 0; seen = 1'b0;
        do begin
            step(); n++;
            if (ov) begin seen = 1'b1; chk("b2b first", ost, ref_imc(s)); end
        end while (!ir && n < 20);
        chk("b2b first_seen", seen, 1'b1);
        chk("b2b second_accept", n + 1, 6);
        step();
        iv = 1'b0;
        cyc = 1;
        while (!ov && cyc < 20) begin step(); cyc++; end
        chk("b2b second latency", cyc, 5);
        chk("b2b second data", ost, {4{32'h2d26314c}});
        step();

        fl = 1'b1; iv = 1'b1; ist = s;
        step();
        chk("flush_idle", {ir, bz, ov}, 3'b100);
        fl = 1'b0; iv = 1'b0;

        s = {$urandom, $urandom, $urandom, $urandom};
        ist = s; iv = 1'b1;
        step();
        iv = 1'b0;
        step();
        step();
        chk("flush pre", bz, 1'b1);
        fl = 1'b1;
        step();
        fl = 1'b0;
        chk("flush state", {ir, bz, ov}, 3'b100);
        chk("flush partial", ost[127:64], ref_imc(s)[127:64]);
        seen = 1'b0;
        for (int t = 0; t < 6; t++) begin step(); seen |= ov; end
        chk("flush no_valid", seen, 1'b0);
        run_block({4{32'hc6c6c6c6}}, 1'b0, "post_flush");
        chk("post_flush const", ost, {4{32'hc6c6c6c6}});

        s = {$urandom, $urandom, $urandom, $urandom};
        ordy = 1'b0; ist = s; iv = 1'b1;
        step();
        iv = 1'b0;
        cyc = 1;
        while (!ov && cyc < 20) begin step(); cyc++; end
        chk("rst done", {ov, cyc[3:0]}, {1'b1, 4'd5});
        #2 rst_n = 1'b0;
        #1;
        chk("async rst flags", {ov, ir, bz}, 3'b010);
        chk("async rst data", ost, '0);
        #1 rst_n = 1'b1;
        step();
        chk("after rst", {ir, ov}, 2'b10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/inv_mixcol_seq.md
Name: inv_mixcol_seq

Overview:
- Iterative InvMixColumns engine for the AES decryption round datapath.
- Accepts a 128-bit state, processes one column per clock through one shared bank of constant-multiplier lookup tables (x09, x0b, x0d, x0e; four of each), and returns the transformed state.
- Sits between InvSubBytes/AddRoundKey and the round register; the round controller drives it with a valid/ready handshake.
- A bypass option serves the final decryption round, which skips InvMixColumns.

Parameters:
- BYPASS_EN, 1, when 0 in_bypass is ignored and treated as 0.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input state is valid.
- in_ready  output  1  block can accept a state.
- in_state  input  128  state; byte k = in_state[127-8k -: 8]; column c = bytes 4c..4c+3 (byte 4c is row 0).
- in_bypass  input  1  pass state unchanged (final round); sampled with in_state.
- flush  input  1  synchronous abort; returns the block to IDLE.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_state  output  128  result, same byte ordering as in_state.
- busy  output  1  high in the BUSY state.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; col_cnt=0.
  - in_ready=1 (combinational from IDLE), out_valid=0, out_state=0, busy=0.
  - Internal state and result registers clear to 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1 the block accepts the input: it latches in_state into src_reg and latches the bypass flag.
  - Bypass=1: result_reg <= in_state, next state DONE.
  - Bypass=0: col_cnt <= 0, next state BUSY.
- BUSY:
  - in_ready=0, busy=1.
  - Each cycle, column col_cnt (a0..a3) of src_reg drives the shared LUT bank:
    - b0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3
    - b1 = 09·a0 ^ 0e·a1 ^ 0b·a2 ^ 0d·a3
    - b2 = 0d·a0 ^ 09·a1 ^ 0e·a2 ^ 0b·a3
    - b3 = 0b·a0 ^ 0d·a1 ^ 09·a2 ^ 0e·a3
  - {b0,b1,b2,b3} is written into the column col_cnt slot of result_reg; col_cnt increments.
  - After col_cnt=3 the next state is DONE and col_cnt wraps to 0.
  - All arithmetic is GF(2^8) XOR of table outputs; there are no carries.
- DONE:
  - out_valid=1; out_state=result_reg, held stable while out_ready=0.
  - On out_ready=1, next state is IDLE and out_valid drops the next cycle.
  - in_ready is 0 in DONE; there is no overlap between consecutive blocks.
- Latency, counting accept edge = cycle 0:
  - Normal: out_valid is high from cycle 5 (4 BUSY cycles plus the DONE register). The earliest handshake completes at cycle 5, and the next accept is possible at cycle 6.
  - Bypass: out_valid is high from cycle 1 (one cycle after the accept edge).
- flush:
  - Takes priority over every transition; next state is IDLE.
  - out_valid drops next cycle, col_cnt=0; result_reg is not cleared.
  - flush=1 together with in_valid in IDLE: the input is not accepted.
- Reset mid-operation: immediate return to the reset values; the partial result is discarded.
- in_state and in_bypass are ignored when in_ready=0.
- out_state only changes when result_reg is written. Column 0 is written in the first BUSY cycle, so out_state may show partial data while out_valid=0.

Test Plan:
- Single column vectors, all four columns: in_state=8e4da1bc_9fdc589d_01010101_d5d5d7d6, bypass=0, out_ready=1 -> out_state=db135345_f20a225c_01010101_d4d4d4d5; out_valid rises exactly 5 cycles after the accept edge and lasts 1 cycle.
- Bypass: in_state=00112233_44556677_8899aabb_ccddeeff, in_bypass=1 -> out_state is identical, out_valid 1 cycle after accept. Repeat with BYPASS_EN=0 -> InvMixColumns is applied.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_state is stable, in_ready=0, and a new in_valid is not accepted. out_ready=1 -> IDLE next cycle, in_ready=1.
- Back-to-back: two states with in_valid held and out_ready=1 -> the second accept occurs 6 cycles after the first; both results are correct (second: 4d7ebdf8 ×4 columns -> 2d26314c ×4).
- Flush in BUSY at col_cnt=2 -> IDLE next cycle, out_valid never asserts. The next block (c6c6c6c6 ×4) -> c6c6c6c6 ×4 with normal latency.
- Async reset asserted in DONE with out_valid=1 -> out_valid=0 and out_state=0 immediately, without waiting for a clock edge; in_ready=1 after rst_n deasserts.
